// File: rtl/text_glyph_ctrl.sv
// text_glyph_ctrl: text-window glyph sequencer for the 8x16 character ROM.
// Keeps a COLS x ROWS buffer of character codes with blink attributes, maps
// each raster pixel to its cell and glyph row, drives the ROM address, and
// produces the foreground pixel with sync/video delayed to stay aligned
// (fixed 2-cycle latency).
module text_glyph_ctrl #(
    parameter int COLS         = 16,
    parameter int ROWS         = 4,
    parameter int X_ORG        = 64,
    parameter int Y_ORG        = 32,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       wr_req,
    input  logic [5:0] wr_addr,
    input  logic [4:0] wr_code,
    input  logic       wr_blink,
    output logic       wr_ack,
    output logic       wr_err,
    output logic [3:0] rom_sel,
    output logic [1:0] rom_ad,
    output logic [3:0] rom_lsby,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic       video_on_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       blink_phase
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int FW    = $clog2(BLINK_FRAMES + 1);

    // Text buffer: character code and blink attribute per cell
    logic [4:0]       code_mem [CELLS];
    logic [CELLS-1:0] blink_mem;

    // Window geometry (11-bit so that x < X_ORG wraps high and fails the range test)
    logic [10:0]   dx, dy;
    logic          in_window;
    logic [AW-1:0] rd_idx;
    logic [4:0]    rd_code;
    logic          rd_blink;

    // Write side
    logic          wr_take;
    logic          wr_in_range;
    logic [AW-1:0] wr_idx;

    // Stage-1 registers
    logic [2:0]    bit_s1;
    logic          win_s1, blank_s1, blinked_s1;
    logic          vid_s1, hs_s1, vs_s1;

    // Blink frame counter
    logic [FW-1:0] frame_cnt;

    assign dx        = {1'b0, pixel_x} - 11'(X_ORG);
    assign dy        = {1'b0, pixel_y} - 11'(Y_ORG);
    assign in_window = (dx < 11'(8 * COLS)) && (dy < 11'(16 * ROWS));
    assign rd_idx    = AW'(32'(dy[10:4]) * 32'(COLS) + 32'(dx[10:3]));
    assign rd_code   = code_mem[rd_idx];
    assign rd_blink  = blink_mem[rd_idx];

    assign wr_take     = wr_req & ~wr_ack;
    assign wr_in_range = 32'(wr_addr) < 32'(CELLS);
    assign wr_idx      = wr_addr[AW-1:0];

    // Buffer storage: cleared to blank on reset, written on an accepted in-range request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the buffer must come up blank, so it is a reset register array rather than a RAM.
            for (int i = 0; i < CELLS; i++) code_mem[i] <= '0;
            blink_mem <= '0;
        end else if (wr_take && wr_in_range) begin
            // NOTE: non-blocking writes keep a same-cycle read of this cell returning the old value.
            code_mem[wr_idx]  <= wr_code;
            blink_mem[wr_idx] <= wr_blink;
        end
    end

    // Write handshake: one-cycle ack, no new request taken while ack is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_take;
            wr_err <= wr_take & ~wr_in_range;
        end
    end

    // Blink timing: count vsync rising edges, toggle the phase every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (vsync_in && !vs_s1) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Stage 1: cell lookup and ROM addressing; ROM fields hold outside the window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_sel    <= '0;
            rom_ad     <= '0;
            rom_lsby   <= '0;
            bit_s1     <= '0;
            win_s1     <= 1'b0;
            blank_s1   <= 1'b0;
            blinked_s1 <= 1'b0;
            vid_s1     <= 1'b0;
            hs_s1      <= 1'b0;
            vs_s1      <= 1'b0;
        end else begin
            win_s1 <= in_window;
            vid_s1 <= video_on;
            hs_s1  <= hsync_in;
            vs_s1  <= vsync_in;
            if (in_window) begin
                rom_sel    <= {1'b0, rd_code[4:2]};
                rom_ad     <= rd_code[1:0];
                rom_lsby   <= dy[3:0];
                bit_s1     <= dx[2:0];
                blank_s1   <= (rd_code[4:2] == 3'd0);
                blinked_s1 <= rd_blink & blink_phase;
            end
        end
    end

    // Stage 2: glyph bit select and aligned sync/video outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_on     <= 1'b0;
            video_on_out <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            pixel_on     <= vid_s1 & win_s1 & ~blank_s1 & ~blinked_s1 & rom_data[3'd7 - bit_s1];
            video_on_out <= vid_s1;
            hsync_out    <= hs_s1;
            vsync_out    <= vs_s1;
        end
    end

endmodule
